// File: rtl/uart_rx_packer_pkg.sv
// ============================================================================
// Module   : uart_rx_packer_pkg
// Purpose  : Shared packer state encoding and counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_packer_pkg;

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } pack_state_e;

   // Never returns zero so that single-entry counters still get a register bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_packer_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock word FIFO; the caller gates push/pop against full/empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
   import uart_rx_packer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = cnt_width(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == c_full_count);
   assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_rx_packer.sv
// ============================================================================
// Module   : uart_rx_packer
// Purpose  : Buffers received words and packs R of them per valid/ready beat,
//            flagging the last beat of each frame. Define PACKER_OVF_EN to get
//            the sticky ovf output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_packer
   import uart_rx_packer_pkg::*;
#(
   parameter int W_IN            = 16,
   parameter int R               = 4,
   parameter int DEPTH           = 8,
   parameter int BEATS_PER_FRAME = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              s_valid,
   input  logic [W_IN-1:0]   s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [R*W_IN-1:0] m_data,
   output logic              m_last
`ifdef PACKER_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int KW = $clog2(R + 1);
   localparam int BW = cnt_width(BEATS_PER_FRAME);
   localparam logic [KW-1:0] c_k_full    = KW'(R);
   localparam logic [BW-1:0] c_beat_last = BW'(BEATS_PER_FRAME - 1);

   pack_state_e      r_state;
   pack_state_e      w_state_nxt;
   logic [KW-1:0]    r_k;
   logic [KW-1:0]    w_k_nxt;
   logic [KW-1:0]    w_slot;
   logic [BW-1:0]    r_beat;
   logic [W_IN-1:0]  r_slot [R];
   logic [W_IN-1:0]  w_fifo_data;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_hs;

   assign m_valid = (r_state == ST_HOLD);
   assign w_hs    = m_valid && m_ready;
   assign w_pop   = !w_empty && (!m_valid || w_hs);
   assign w_push  = s_valid && (!w_full || w_pop);

   sync_fifo #(
      .WIDTH (W_IN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (s_data),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_FILL;
         r_k     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
      end
   end

   // A handshake frees the beat, so a word popped alongside it starts the next one.
   always_comb begin
      w_k_nxt     = r_k;
      w_state_nxt = r_state;
      if (w_pop) begin
         w_k_nxt = w_hs ? KW'(1) : r_k + KW'(1);
      end else if (w_hs) begin
         w_k_nxt = '0;
      end
      case (r_state)
         ST_FILL: if (w_k_nxt == c_k_full) w_state_nxt = ST_HOLD;
         ST_HOLD: if (w_k_nxt != c_k_full) w_state_nxt = ST_FILL;
         default: w_state_nxt = ST_FILL;
      endcase
   end

   assign w_slot = w_hs ? '0 : r_k;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < R; i++) r_slot[i] <= '0;
      end else begin
         for (int i = 0; i < R; i++) begin
            if (w_pop && (w_slot == KW'(i))) r_slot[i] <= w_fifo_data;
         end
      end
   end

   for (genvar gi = 0; gi < R; gi++) begin : g_pack
      assign m_data[gi*W_IN +: W_IN] = r_slot[gi];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_beat <= '0;
      end else if (w_hs) begin
         r_beat <= (r_beat == c_beat_last) ? '0 : r_beat + BW'(1);
      end
   end

   assign m_last = m_valid && (r_beat == c_beat_last);

`ifdef PACKER_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ovf <= 1'b0;
      end else if (s_valid && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_packer.sv
// ============================================================================
// Module   : tb_uart_rx_packer
// Purpose  : Directed self-checking bench for uart_rx_packer (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_packer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        s_valid;
   logic [15:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_data;
   logic        m_last;
`ifdef PACKER_OVF_EN
   logic        ovf;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_beats  = 0;
   logic [15:0] exp_q [$];
   logic [63:0] held;

   uart_rx_packer #(
      .W_IN            (16),
      .R               (4),
      .DEPTH           (8),
      .BEATS_PER_FRAME (8)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .s_valid (s_valid),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
`ifdef PACKER_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Beat about to be accepted: compare against the next four queued words.
   task automatic check_beat();
      logic [63:0] e;
      e = '0;
      check("beat_expected", 64'(exp_q.size() >= 4), 64'd1);
      for (int i = 0; i < 4; i++) begin
         if (exp_q.size() > 0) e[i*16 +: 16] = exp_q.pop_front();
      end
      check("beat_data", m_data, e);
      check("beat_last", 64'(m_last), 64'((n_beats % 8) == 7));
      n_beats++;
   endtask

   task automatic cycle(input logic sv, input logic [15:0] d);
      if (m_valid && m_ready) check_beat();
      s_valid = sv;
      s_data  = d;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [15:0] d);
      exp_q.push_back(d);
      cycle(1'b1, d);
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      exp_q.delete();
      n_beats = 0;
   endtask

   initial begin
      rstn    = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", m_data, 64'd0);
      check("rst_m_last", 64'(m_last), 64'd0);
`ifdef PACKER_OVF_EN
      check("rst_ovf", 64'(ovf), 64'd0);
`endif

      // Reset mid-beat discards the partial beat
      rstn = 1'b1;
      cycle(1'b1, 16'hAAAA);
      cycle(1'b1, 16'hBBBB);
      rstn = 1'b0;
      cycle(1'b0, 16'h0);
      rstn = 1'b1;
      check("midrst_m_valid", 64'(m_valid), 64'd0);
      check("midrst_m_data", m_data, 64'd0);
      cycle(1'b1, 16'h1111);
      cycle(1'b1, 16'h2222);
      cycle(1'b1, 16'h3333);
      cycle(1'b1, 16'h4444);
      cycle(1'b0, 16'h0);
      check("midrst_beat_valid", 64'(m_valid), 64'd1);
      check("midrst_beat_data", m_data, 64'h4444_3333_2222_1111);
      check("midrst_beat_last", 64'(m_last), 64'd0);

      // Basic pack: valid for exactly one cycle
      do_reset();
      m_ready = 1'b1;
      cycle(1'b1, 16'h0001);
      cycle(1'b1, 16'h0002);
      cycle(1'b1, 16'h0003);
      check("basic_not_early", 64'(m_valid), 64'd0);
      cycle(1'b1, 16'h0004);
      check("basic_latency", 64'(m_valid), 64'd0);
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      check("basic_valid", 64'(m_valid), 64'd1);
      check("basic_data", m_data, 64'h0004_0003_0002_0001);
      check("basic_last", 64'(m_last), 64'd0);
      @(posedge clk);
      #1;
      check("basic_valid_drop", 64'(m_valid), 64'd0);

      // Backpressure: 12 words fit (4 in packer, 8 in FIFO)
      do_reset();
      for (int i = 1; i <= 12; i++) push_exp(16'(16'h0100 + i));
      check("bp_valid", 64'(m_valid), 64'd1);
      check("bp_data", m_data, 64'h0104_0103_0102_0101);
      held = m_data;
      repeat (3) cycle(1'b0, 16'h0);
      check("bp_hold_valid", 64'(m_valid), 64'd1);
      check("bp_hold_data", m_data, held);
      m_ready = 1'b1;
      repeat (12) cycle(1'b0, 16'h0);
      check("bp_beats", 64'(n_beats), 64'd3);
      check("bp_drained", 64'(exp_q.size()), 64'd0);
      check("bp_idle", 64'(m_valid), 64'd0);

      // Overflow: words 13 and 14 are dropped
      do_reset();
      for (int i = 1; i <= 12; i++) push_exp(16'(16'h0200 + i));
      cycle(1'b1, 16'h020D);
      cycle(1'b1, 16'h020E);
`ifdef PACKER_OVF_EN
      check("ovf_set", 64'(ovf), 64'd1);
`endif
      m_ready = 1'b1;
      repeat (16) cycle(1'b0, 16'h0);
      check("ovf_beats", 64'(n_beats), 64'd3);
      check("ovf_drained", 64'(exp_q.size()), 64'd0);
      check("ovf_no_extra", 64'(m_valid), 64'd0);
`ifdef PACKER_OVF_EN
      check("ovf_sticky", 64'(ovf), 64'd1);
`endif

      // Frame marker over 9 beats
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 36; i++) push_exp(16'(16'h3000 + i));
      repeat (4) cycle(1'b0, 16'h0);
      check("frame_beats", 64'(n_beats), 64'd9);
      check("frame_drained", 64'(exp_q.size()), 64'd0);

      // Push into a full FIFO while the held beat handshakes
      do_reset();
      for (int i = 1; i <= 12; i++) push_exp(16'(16'h4000 + i));
      check("fullpop_hold", 64'(m_valid), 64'd1);
      m_ready = 1'b1;
      for (int i = 13; i <= 16; i++) push_exp(16'(16'h4000 + i));
      repeat (10) cycle(1'b0, 16'h0);
      check("fullpop_beats", 64'(n_beats), 64'd4);
      check("fullpop_drained", 64'(exp_q.size()), 64'd0);
`ifdef PACKER_OVF_EN
      check("fullpop_no_ovf", 64'(ovf), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
